// File: rtl/alu_issue_ctrl.sv
// Issue/capture front-end for the 32-bit combinational ALU: registers operands, waits
// SETTLE_CYCLES, then captures the result. Optional sticky overflow via ALU_STICKY_OVF_EN.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_x,
  input  logic [31:0] cmd_y,
  input  logic [3:0]  cmd_op,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_z,
  input  logic        alu_equal,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_z,
  output logic        res_equal,
  output logic        res_overflow,
  output logic        res_zero,
  output logic        res_illegal,
`ifdef ALU_STICKY_OVF_EN
  input  logic        clr_sticky,
  output logic        ovf_sticky,
`endif
  output logic        busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] res_z_q, res_z_d;
  logic        res_equal_q, res_equal_d, res_overflow_q, res_overflow_d;
  logic        res_zero_q, res_zero_d, res_illegal_q, res_illegal_d;

  function automatic logic op_legal(input logic [3:0] op);
    return !((op == 4'd4) || (op > 4'd10));
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_x_d        = alu_x_q;
    alu_y_d        = alu_y_q;
    alu_op_d       = alu_op_q;
    res_z_d        = res_z_q;
    res_equal_d    = res_equal_q;
    res_overflow_d = res_overflow_q;
    res_zero_d     = res_zero_q;
    res_illegal_d  = res_illegal_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          alu_x_d  = cmd_x;
          alu_y_d  = cmd_y;
          alu_op_d = cmd_op;
          if (op_legal(cmd_op)) begin
            state_d = StSettle;
            cnt_d   = 8'(SETTLE_CYCLES - 1);
          end else begin
            // Reserved op: skip the ALU entirely and report a zeroed, flagged result.
            state_d        = StDone;
            res_z_d        = '0;
            res_equal_d    = 1'b0;
            res_overflow_d = 1'b0;
            res_zero_d     = 1'b0;
            res_illegal_d  = 1'b1;
          end
        end
      end
      StSettle: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d        = StDone;
          res_z_d        = alu_z;
          res_equal_d    = alu_equal;
          res_overflow_d = alu_overflow;
          res_zero_d     = alu_zero;
          res_illegal_d  = 1'b0;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      alu_x_q        <= '0;
      alu_y_q        <= '0;
      alu_op_q       <= '0;
      res_z_q        <= '0;
      res_equal_q    <= 1'b0;
      res_overflow_q <= 1'b0;
      res_zero_q     <= 1'b0;
      res_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_x_q        <= alu_x_d;
      alu_y_q        <= alu_y_d;
      alu_op_q       <= alu_op_d;
      res_z_q        <= res_z_d;
      res_equal_q    <= res_equal_d;
      res_overflow_q <= res_overflow_d;
      res_zero_q     <= res_zero_d;
      res_illegal_q  <= res_illegal_d;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic capture;
  logic ovf_sticky_q, ovf_sticky_d;

  assign capture = (state_q == StSettle) && (cnt_q == 8'd0);

  // Set is applied after clear so a same-edge set wins.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (clr_sticky) ovf_sticky_d = 1'b0;
    if (capture && alu_overflow) ovf_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_sticky_q <= 1'b0;
    else     ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

  assign cmd_ready    = (state_q == StIdle);
  assign res_valid    = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign alu_x        = alu_x_q;
  assign alu_y        = alu_y_q;
  assign alu_op       = alu_op_q;
  assign res_z        = res_z_q;
  assign res_equal    = res_equal_q;
  assign res_overflow = res_overflow_q;
  assign res_zero     = res_zero_q;
  assign res_illegal  = res_illegal_q;

endmodule
